// File: rtl/batcher_pkg.sv
// ============================================================================
//  Module   : batcher_pkg
//  Purpose  : Shared types and helpers for the block batcher.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package batcher_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] c_PAD_WORD_DEFAULT = 8'h00;

    // Bit offset of arrival slot k inside the block.
    function automatic int slot_lsb(input int k, input int in_w, input int blk_w, input bit msb_first);
        return msb_first ? (blk_w - (k + 1) * in_w) : (k * in_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bb_out_slice.sv
// ============================================================================
//  Module   : bb_out_slice
//  Purpose  : Valid/ready output register holding one finished block.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bb_out_slice #(
    parameter int BLK_W = 128,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [BLK_W-1:0] i_data,
    input  logic [CW-1:0]    i_count,
    input  logic             i_last,
    input  logic             i_ready,
    output logic [BLK_W-1:0] o_data,
    output logic             o_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_last
);

    logic [BLK_W-1:0] r_data;
    logic             r_valid;
    logic [CW-1:0]    r_count;
    logic             r_last;

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_count <= i_count;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/block_batcher.sv
// ============================================================================
//  Module   : block_batcher
//  Purpose  : Packs IN_W-bit words into BLK_W-bit blocks with flush/padding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_batcher
    import batcher_pkg::*;
#(
    parameter int              IN_W      = 8,
    parameter int              BLK_W     = 128,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [IN_W-1:0] PAD_WORD  = IN_W'(c_PAD_WORD_DEFAULT),
    localparam int             N         = BLK_W / IN_W,
    localparam int             CW        = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [BLK_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_last
);

    localparam logic [BLK_W-1:0] c_PAD_BLOCK = {N{PAD_WORD}};

    generate
        if ((N < 2) || (N * IN_W != BLK_W)) begin : g_param_check
            $error("block_batcher: BLK_W must be an integer multiple (>= 2) of IN_W");
        end
    endgenerate

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [BLK_W-1:0] r_acc;
    logic [CW-1:0]    r_close_cnt;
    logic             r_close_flush;

    logic             w_out_free;
    logic             w_acc;
    logic             w_load;
    logic             w_close;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_cnt_next;
    logic [BLK_W-1:0] w_acc_next;

    assign w_out_free = !out_valid || out_ready;
    assign in_ready   = (r_state == FILL) || w_out_free;
    assign w_acc      = in_valid && in_ready;
    assign w_load     = (r_state == HOLD) && w_out_free;

    // A HOLD transfer empties the accumulator, so a word arriving alongside it lands in slot 0.
    assign w_cnt_base = (r_state == FILL) ? r_cnt : '0;
    assign w_cnt_next = w_cnt_base + CW'(w_acc);
    assign w_close    = in_ready &&
                        ((w_acc && (w_cnt_base == CW'(N - 1))) ||
                         (flush && ((w_cnt_base != '0) || w_acc)));

    always_comb begin
        w_acc_next = w_load ? c_PAD_BLOCK : r_acc;
        for (int k = 0; k < N; k++) begin
            if (w_acc && (w_cnt_base == CW'(k))) begin
                w_acc_next[slot_lsb(k, IN_W, BLK_W, MSB_FIRST) +: IN_W] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FILL;
            r_cnt         <= '0;
            r_acc         <= c_PAD_BLOCK;
            r_close_cnt   <= '0;
            r_close_flush <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            if (w_close) begin
                r_state       <= HOLD;
                r_cnt         <= '0;
                r_close_cnt   <= w_cnt_next;
                r_close_flush <= flush;
            end else if (in_ready) begin
                r_state <= FILL;
                r_cnt   <= w_cnt_next;
            end
        end
    end

    bb_out_slice #(
        .BLK_W (BLK_W),
        .CW    (CW)
    ) u_out_slice (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_data  (r_acc),
        .i_count (r_close_cnt),
        .i_last  (r_close_flush),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_count (out_count),
        .o_last  (out_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_block_batcher.sv
// ============================================================================
//  Module   : tb_block_batcher
//  Purpose  : Self-checking bench for block_batcher (both slot orders).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_batcher;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         flush;
    logic         out_ready;
    logic         in_ready,  in_ready_l;
    logic [127:0] out_data,  out_data_l;
    logic         out_valid, out_valid_l;
    logic [4:0]   out_count, out_count_l;
    logic         out_last,  out_last_l;

    block_batcher #(.IN_W(8), .BLK_W(128), .MSB_FIRST(1'b1), .PAD_WORD(8'h00)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_last(out_last));

    block_batcher #(.IN_W(8), .BLK_W(128), .MSB_FIRST(1'b0), .PAD_WORD(8'h00)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .flush(flush), .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_count(out_count_l), .out_last(out_last_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: closed blocks awaiting consumption plus the words of the open block.
    typedef struct {
        logic [127:0] dm;
        logic [127:0] dl;
        int           cnt;
        bit           last;
        int           vis;
    } blk_t;

    blk_t       blocks[$];
    logic [7:0] cur[$];
    int         edge_cnt;
    bit         exp_ready;
    bit         exp_valid;
    blk_t       head;
    int         total;
    int         bad;

    task automatic drive(input bit iv, input logic [7:0] d, input bit fl, input bit ordy);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        // With two closed blocks outstanding both buffers are full.
        exp_ready = (blocks.size() < 2) || ordy;
        exp_valid = (blocks.size() > 0) && (blocks[0].vis <= edge_cnt);
        if (exp_valid) head = blocks[0];
    endtask

    task automatic advance();
        bit   acc;
        blk_t b;
        logic [7:0] w;
        acc = in_valid && exp_ready;
        if (exp_valid && out_ready) void'(blocks.pop_front());
        if (acc) cur.push_back(in_data);
        if ((acc && cur.size() == 16) || (flush && cur.size() > 0)) begin
            b.dm = '0;
            b.dl = '0;
            for (int k = 0; k < 16; k++) begin
                w = (k < cur.size()) ? cur[k] : 8'h00;
                b.dm = (b.dm << 8) | 128'(w);
                b.dl = b.dl | (128'(w) << (8 * k));
            end
            b.cnt  = cur.size();
            b.last = flush;
            b.vis  = edge_cnt + 2;
            blocks.push_back(b);
            cur.delete();
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        blocks.delete();
        cur.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_data = 8'h00;
        repeat (2) begin @(posedge clk); edge_cnt++; end
        @(negedge clk);
        model_reset();
        total++;
        if ({out_valid, out_data, out_count, out_last} !== '0) begin
            bad++; $display("FAIL reset_outputs got v=%0b d=%h c=%0d l=%0b exp all zero", out_valid, out_data, out_count, out_last);
        end
        total++;
        if ({out_valid_l, out_data_l, out_count_l, out_last_l} !== '0) begin
            bad++; $display("FAIL reset_outputs_lsb got v=%0b d=%h exp all zero", out_valid_l, out_data_l);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_block();
        int vcount = 0;
        for (int i = 0; i < 22; i++) begin
            drive(i < 16, 8'(i), 1'b0, 1'b1);
            total++;
            if (out_valid !== exp_valid) begin
                bad++; $display("FAIL full_valid cyc=%0d got %0b exp %0b", i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({out_data, out_count, out_last} !== {128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b0}) begin
                    bad++; $display("FAIL full_payload got d=%h c=%0d l=%0b exp d=000102030405060708090a0b0c0d0e0f c=16 l=0", out_data, out_count, out_last);
                end
            end
            if (out_valid === 1'b1) vcount++;
            advance();
        end
        total++;
        if (vcount != 1) begin
            bad++; $display("FAIL full_valid_cycles got %0d exp 1", vcount);
        end
    endtask

    task automatic test_lsb_order();
        for (int i = 0; i < 20; i++) begin
            drive(i < 16, 8'(i), 1'b0, 1'b1);
            total++;
            if (out_valid_l !== exp_valid) begin
                bad++; $display("FAIL lsb_valid cyc=%0d got %0b exp %0b", i, out_valid_l, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({out_data_l, out_count_l, out_last_l} !== {128'h0F0E0D0C0B0A09080706050403020100, 5'd16, 1'b0}) begin
                    bad++; $display("FAIL lsb_payload got d=%h c=%0d l=%0b exp d=0f0e0d0c0b0a09080706050403020100 c=16 l=0", out_data_l, out_count_l, out_last_l);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int fell_at = -1;
        for (int cyc = 0; cyc < 66; cyc++) begin
            drive(idx < 40, 8'(idx), (cyc == 60), (cyc >= 40));
            total++;
            if (in_ready !== exp_ready) begin
                bad++; $display("FAIL bp_in_ready cyc=%0d got %0b exp %0b", cyc, in_ready, exp_ready);
            end
            total++;
            if (out_valid !== exp_valid) begin
                bad++; $display("FAIL bp_valid cyc=%0d got %0b exp %0b", cyc, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({out_data, out_count, out_last} !== {head.dm, 5'(head.cnt), head.last}) begin
                    bad++; $display("FAIL bp_payload cyc=%0d got d=%h c=%0d l=%0b exp d=%h c=%0d l=%0b", cyc, out_data, out_count, out_last, head.dm, head.cnt, head.last);
                end
            end
            if (in_ready === 1'b0 && fell_at < 0) fell_at = idx;
            if (idx < 40 && exp_ready) idx++;
            advance();
        end
        total++;
        if (fell_at != 32) begin
            bad++; $display("FAIL bp_fall_point got %0d accepts exp 32", fell_at);
        end
    endtask

    task automatic test_flush_partial();
        for (int i = 0; i < 16; i++) begin
            drive(i < 5, 8'hA0 + 8'(i), (i == 5) || (i == 10), 1'b1);
            total++;
            if (out_valid !== exp_valid) begin
                bad++; $display("FAIL flush_valid cyc=%0d got %0b exp %0b", i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({out_data, out_count, out_last} !== {40'hA0A1A2A3A4, 88'h0, 5'd5, 1'b1}) begin
                    bad++; $display("FAIL flush_payload got d=%h c=%0d l=%0b exp d=a0a1a2a3a4 + pad c=5 l=1", out_data, out_count, out_last);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_with_word();
        logic [7:0] seq [6] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1};
        for (int i = 0; i < 12; i++) begin
            drive(i < 6, (i < 6) ? seq[i] : 8'h00, (i == 3) || (i == 5), 1'b1);
            total++;
            if (out_valid !== exp_valid) begin
                bad++; $display("FAIL fw_valid cyc=%0d got %0b exp %0b", i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({out_data, out_count, out_last, out_data_l} !== {head.dm, 5'(head.cnt), head.last, head.dl}) begin
                    bad++; $display("FAIL fw_payload cyc=%0d got d=%h c=%0d l=%0b dl=%h exp d=%h c=%0d l=%0b dl=%h", i, out_data, out_count, out_last, out_data_l, head.dm, head.cnt, head.last, head.dl);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_block();
        int vcount = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1);
            advance();
        end
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); edge_cnt++; @(negedge clk);
        model_reset();
        total++;
        if ({out_valid, out_data, out_count, out_last} !== '0) begin
            bad++; $display("FAIL midreset_outputs got v=%0b d=%h c=%0d l=%0b exp all zero", out_valid, out_data, out_count, out_last);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(i < 16, 8'(i), 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                vcount++;
                total++;
                if ({out_data, out_count, out_last} !== {128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b0}) begin
                    bad++; $display("FAIL midreset_payload got d=%h c=%0d l=%0b exp case-1 block", out_data, out_count, out_last);
                end
            end
            advance();
        end
        total++;
        if (vcount != 1) begin
            bad++; $display("FAIL midreset_blocks got %0d exp 1", vcount);
        end
    endtask

    task automatic test_random();
        bit iv, fl, ordy;
        for (int i = 0; i < 600; i++) begin
            iv   = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 9) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            if (i >= 590) begin iv = 1'b0; fl = (i == 590); ordy = 1'b1; end
            drive(iv, 8'($urandom), fl, ordy);
            total++;
            if ({in_ready, in_ready_l} !== {exp_ready, exp_ready}) begin
                bad++; $display("FAIL rnd_in_ready cyc=%0d got %0b/%0b exp %0b", i, in_ready, in_ready_l, exp_ready);
            end
            total++;
            if ({out_valid, out_valid_l} !== {exp_valid, exp_valid}) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got %0b/%0b exp %0b", i, out_valid, out_valid_l, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({out_data, out_count, out_last, out_data_l, out_count_l, out_last_l} !==
                    {head.dm, 5'(head.cnt), head.last, head.dl, 5'(head.cnt), head.last}) begin
                    bad++; $display("FAIL rnd_payload cyc=%0d got d=%h dl=%h c=%0d l=%0b exp d=%h dl=%h c=%0d l=%0b", i, out_data, out_data_l, out_count, out_last, head.dm, head.dl, head.cnt, head.last);
                end
            end
            advance();
        end
    endtask

    initial begin
        total = 0; bad = 0; edge_cnt = 0;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_full_block();
        test_lsb_order();
        test_backpressure();
        test_flush_partial();
        test_flush_with_word();
        test_reset_mid_block();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
